cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
//   Exception/interrupt sequencer for CP0. Synchronises external IRQ lines and builds IP[7:0] for the
//   CAUSE register. Picks the highest-priority pending exception and stalls/drains the pipeline. Then
//   pulses activeexception/exccode into CAUSE, writes EPC and redirects fetch to the vector. EXL is
//   owned here and held until ERET. Sits between the pipeline, CP0 STATUS/CAUSE/EPC and fetch.
// PARAMETERS
//   VECTOR_ADDR  32'h8000_0180  general exception vector driven on redirect_pc
//   SYNC_STAGES  2              flops per IRQ synchroniser (>=2)
// PORTS
//   clk            in   1   core clock, all state on rising edge
//   reset          in   1   asynchronous, active-low (0 = reset)
//   irq            in   5   async external IRQ lines -> IP[6:2]
//   timer_pending  in   1   synchronous timer compare pending -> IP[7]
//   sw_int         in   2   software interrupt bits from CAUSE write -> IP[1:0]
//   status_ie      in   1   STATUS.IE
//   status_im      in   8   STATUS.IM[15:8]
//   exc_req        in   6   sync exc, one-hot-or-more: [5]AdEL [4]RI [3]Ov [2]Sys [1]Bp [0]AdES
//   exc_pc         in   32  PC of the excepting/interrupted instruction, valid with request
//   pipe_drained   in   1   pipeline acknowledges stall, no instruction in flight
//   redirect_ready in   1   fetch accepts redirect
//   eret           in   1   one-cycle ERET retire pulse
//   interrupts     out  8   IP[7:0] = {timer_pending, irq_sync[4:0], sw_int}
//   stall_req      out  1   freeze/drain request to pipeline
//   activeexception out 1   one-cycle commit pulse to CAUSE
//   exccode        out  5   ExcCode, valid while activeexception=1
//   epc_we         out  1   EPC write enable (one cycle, with activeexception)
//   epc            out  32  value for EPC
//   redirect_valid out  1   fetch redirect request
//   redirect_pc    out  32  = VECTOR_ADDR
//   exl            out  1   STATUS.EXL
// BEHAVIOUR
//   Reset (async, reset=0): state IDLE; all outputs 0; synchronisers cleared; exl=0; epc=0.
//   IP path: irq through SYNC_STAGES flops, then an output register. Latency irq->interrupts is
//     SYNC_STAGES+1 cycles. timer_pending and sw_int are registered once (1 cycle).
//   int_pend = status_ie & ~exl & |(interrupts & status_im).
//   Priority (high->low): AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdES(5) > Int(0).
//     Sync exc_req always wins over int_pend in the same cycle.
//   FSM:
//     IDLE:     if |exc_req or int_pend: latch code, latch exc_pc, set stall_req=1 -> DRAIN.
//     DRAIN:    stall_req=1; wait pipe_drained=1 -> COMMIT. Later requests are ignored; the
//               code latched on entry is kept.
//     COMMIT:   exactly 1 cycle: activeexception=1, exccode=latched, epc=latched PC,
//               epc_we=~exl (nested exception under EXL does not overwrite EPC), exl<=1 -> REDIRECT.
//     REDIRECT: redirect_valid=1, redirect_pc=VECTOR_ADDR, stall_req=1.
//               Hold until redirect_ready=1 (that cycle is the transfer) -> HANDLER.
//     HANDLER:  stall_req=0, exl=1; interrupts masked by exl.
//               |exc_req: latch, stall_req=1 -> DRAIN (nested; EPC kept).
//               else eret=1: exl<=0 -> IDLE. If both in the same cycle, the exception wins and
//               eret is ignored.
//   eret outside HANDLER is ignored. exc_req/int_pend are sampled only in IDLE/HANDLER.
//   redirect_valid stays asserted without ready; redirect_pc stable while valid.
//   Reset mid-sequence (any state) returns to IDLE with exl=0 and no pulse emitted.
// TESTING
//   1 irq[2]=1, IM[4]=1, IE=1: interrupts[4]=1 after 3 clk; ExcCode=0 pulse once; epc=exc_pc;
//     redirect_pc=32'h8000_0180.
//   2 exc_req=6'b001001 (Ov+AdES) with int_pend: exccode=12, epc_we=1; activeexception 1 cycle.
//   3 pipe_drained held 0 for 10 cycles: stall_req stays 1, no activeexception until drained.
//   4 In HANDLER exc_req[2] (Sys) with eret same cycle: exccode=8, epc_we=0, exl stays 1.
//   5 redirect_ready low 5 cycles: redirect_valid/redirect_pc stable; HANDLER entered on ready.
//   6 Assert reset=0 during DRAIN: all outputs 0 asynchronously; after release, IDLE, exl=0.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: synchronises IRQs into IP[7:0], prioritises pending causes,
// drains the pipeline, commits CAUSE/EPC, redirects fetch to the vector and owns STATUS.EXL.
module cp0_exc_ctrl #(
  parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  irq,
  input  logic        timer_pending,
  input  logic [1:0]  sw_int,
  input  logic        status_ie,
  input  logic [7:0]  status_im,
  input  logic [5:0]  exc_req,
  input  logic [31:0] exc_pc,
  input  logic        pipe_drained,
  input  logic        redirect_ready,
  input  logic        eret,
  output logic [7:0]  interrupts,
  output logic        stall_req,
  output logic        activeexception,
  output logic [4:0]  exccode,
  output logic        epc_we,
  output logic [31:0] epc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_COMMIT   = 3'd2;
  localparam logic [2:0] S_REDIRECT = 3'd3;
  localparam logic [2:0] S_HANDLER  = 3'd4;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [7:0]  ip_q;
  logic [2:0]  state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;
  logic        int_pend;

  // Synchronous causes beat interrupts; with no exc_req bit set the code is Int (0).
  function automatic logic [4:0] exc_prio(input logic [5:0] req);
    logic [4:0] code;
    if (req[5])      code = 5'd4;
    else if (req[4]) code = 5'd10;
    else if (req[3]) code = 5'd12;
    else if (req[2]) code = 5'd8;
    else if (req[1]) code = 5'd9;
    else if (req[0]) code = 5'd5;
    else             code = 5'd0;
    return code;
  endfunction

  // IRQ synchroniser chain followed by the IP output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      ip_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      ip_q   <= {timer_pending, sync_q[SYNC_STAGES-1], sw_int};
    end
  end

  assign int_pend = status_ie & ~exl_q & (|(ip_q & status_im));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    case (state_q)
      S_IDLE: begin
        if ((|exc_req) || int_pend) begin
          code_d  = exc_prio(exc_req);
          epc_d   = exc_pc;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pipe_drained) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        exl_d   = 1'b1;
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_HANDLER;
      end
      S_HANDLER: begin
        // A nested exception takes precedence over a coincident ERET.
        if (|exc_req) begin
          code_d  = exc_prio(exc_req);
          epc_d   = exc_pc;
          state_d = S_DRAIN;
        end else if (eret) begin
          exl_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        exl_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      epc_q   <= '0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
    end
  end

  // EPC is only written when not already inside a handler, so the outer return PC survives nesting.
  assign interrupts      = ip_q;
  assign stall_req       = (state_q == S_DRAIN) || (state_q == S_COMMIT) || (state_q == S_REDIRECT);
  assign activeexception = (state_q == S_COMMIT);
  assign exccode         = activeexception ? code_q : 5'd0;
  assign epc_we          = activeexception & ~exl_q;
  assign epc             = epc_q;
  assign redirect_valid  = (state_q == S_REDIRECT);
  assign redirect_pc     = redirect_valid ? VECTOR_ADDR : 32'd0;
  assign exl             = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level reference model of the exception sequence.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  irq;
  logic        timer_pending;
  logic [1:0]  sw_int;
  logic        status_ie;
  logic [7:0]  status_im;
  logic [5:0]  exc_req;
  logic [31:0] exc_pc;
  logic        pipe_drained;
  logic        redirect_ready;
  logic        eret;
  logic [7:0]  interrupts;
  logic        stall_req;
  logic        activeexception;
  logic [4:0]  exccode;
  logic        epc_we;
  logic [31:0] epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exl;

  int n_checks = 0;
  int n_err    = 0;

  cp0_exc_ctrl #(.VECTOR_ADDR(VEC), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .irq(irq), .timer_pending(timer_pending), .sw_int(sw_int),
    .status_ie(status_ie), .status_im(status_im), .exc_req(exc_req), .exc_pc(exc_pc),
    .pipe_drained(pipe_drained), .redirect_ready(redirect_ready), .eret(eret),
    .interrupts(interrupts), .stall_req(stall_req), .activeexception(activeexception),
    .exccode(exccode), .epc_we(epc_we), .epc(epc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exl(exl)
  );

  always #5 clk = ~clk;

  // Reference model: where the exception sequence stands, plus the architectural state it owns.
  typedef enum int {PH_IDLE, PH_DRAIN, PH_COMMIT, PH_REDIRECT, PH_HANDLER} phase_t;
  phase_t      phase;
  logic        m_exl;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [7:0]  m_ip;
  logic [4:0]  irq_hist[$];

  function automatic logic [4:0] ref_code(input logic [5:0] req);
    int bit_order[6] = '{5, 4, 3, 2, 1, 0};
    int code_tab[6]  = '{4, 10, 12, 8, 9, 5};
    for (int i = 0; i < 6; i++)
      if (req[bit_order[i]]) return 5'(code_tab[i]);
    return 5'd0;
  endfunction

  task automatic model_reset();
    phase  = PH_IDLE;
    m_exl  = 1'b0;
    m_code = '0;
    m_epc  = '0;
    m_ip   = '0;
    irq_hist.delete();
  endtask

  task automatic model_edge();
    logic pend;
    if (!reset) begin
      model_reset();
    end else begin
      pend = status_ie && !m_exl && ((m_ip & status_im) != 8'd0);
      case (phase)
        PH_IDLE:     if (exc_req != 6'd0 || pend) begin
                       m_code = ref_code(exc_req); m_epc = exc_pc; phase = PH_DRAIN;
                     end
        PH_DRAIN:    if (pipe_drained) phase = PH_COMMIT;
        PH_COMMIT:   begin m_exl = 1'b1; phase = PH_REDIRECT; end
        PH_REDIRECT: if (redirect_ready) phase = PH_HANDLER;
        PH_HANDLER:  if (exc_req != 6'd0) begin
                       m_code = ref_code(exc_req); m_epc = exc_pc; phase = PH_DRAIN;
                     end else if (eret) begin
                       m_exl = 1'b0; phase = PH_IDLE;
                     end
        default:     phase = PH_IDLE;
      endcase
      // IRQ lines appear on IP three edges after they are sampled.
      irq_hist.push_back(irq);
      if (irq_hist.size() > 3) void'(irq_hist.pop_front());
      m_ip = {timer_pending, (irq_hist.size() == 3) ? irq_hist[0] : 5'd0, sw_int};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic in_commit;
    in_commit = (phase == PH_COMMIT);
    chk("interrupts", 32'(interrupts), 32'(m_ip));
    chk("stall_req", 32'(stall_req),
        32'(phase == PH_DRAIN || phase == PH_COMMIT || phase == PH_REDIRECT));
    chk("activeexception", 32'(activeexception), 32'(in_commit));
    chk("exccode", 32'(exccode), in_commit ? 32'(m_code) : 32'd0);
    chk("epc_we", 32'(epc_we), 32'(in_commit && !m_exl));
    chk("epc", epc, m_epc);
    chk("redirect_valid", 32'(redirect_valid), 32'(phase == PH_REDIRECT));
    chk("redirect_pc", redirect_pc, (phase == PH_REDIRECT) ? VEC : 32'd0);
    chk("exl", 32'(exl), 32'(m_exl));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("reset_stall", 32'(stall_req), 32'd0);
    chk("reset_exl", 32'(exl), 32'd0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; irq = '0; timer_pending = 1'b0; sw_int = '0; status_ie = 1'b0;
    status_im = '0; exc_req = '0; exc_pc = '0; pipe_drained = 1'b0; redirect_ready = 1'b0;
    eret = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_interrupts", 32'(interrupts), 32'd0);
    chk("rst_epc", epc, 32'd0);
    reset = 1'b1;

    // IRQ[2] -> IP[4] interrupt taken with ExcCode 0
    status_ie = 1'b1; status_im = 8'h10; irq = 5'b00100; exc_pc = 32'h1234_5678;
    pipe_drained = 1'b1; redirect_ready = 1'b1;
    step(); step();
    chk("t1_ip_not_yet", 32'(interrupts[4]), 32'd0);
    step();
    chk("t1_ip_seen", 32'(interrupts[4]), 32'd1);
    step();
    chk("t1_stall", 32'(stall_req), 32'd1);
    irq = '0;
    step();
    chk("t1_pulse", 32'(activeexception), 32'd1);
    chk("t1_code", 32'(exccode), 32'd0);
    chk("t1_epc", epc, 32'h1234_5678);
    step();
    chk("t1_pulse_once", 32'(activeexception), 32'd0);
    chk("t1_vec", redirect_pc, 32'h8000_0180);
    status_ie = 1'b0;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("t1_exl_clear", 32'(exl), 32'd0);

    // Ov+AdES together with a pending software interrupt: Ov wins
    status_ie = 1'b1; status_im = 8'h01; sw_int = 2'b01;
    step();
    exc_req = 6'b001001; exc_pc = 32'hA000_0040;
    step();
    exc_req = '0; sw_int = '0; status_ie = 1'b0;
    step();
    chk("t2_code", 32'(exccode), 32'd12);
    chk("t2_epc_we", 32'(epc_we), 32'd1);
    step();
    chk("t2_one_cycle", 32'(activeexception), 32'd0);
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;

    // Drain held off for 10 cycles, then redirect held off for 5 cycles
    exc_req = 6'b000010; pipe_drained = 1'b0; exc_pc = 32'h0040_1000;
    step();
    exc_req = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_stall_held", 32'(stall_req), 32'd1);
      chk("t3_no_pulse", 32'(activeexception), 32'd0);
    end
    pipe_drained = 1'b1; redirect_ready = 1'b0;
    step();
    chk("t3_code_bp", 32'(exccode), 32'd9);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_valid_held", 32'(redirect_valid), 32'd1);
      chk("t5_pc_stable", redirect_pc, VEC);
    end
    redirect_ready = 1'b1;
    step();
    chk("t5_handler_stall", 32'(stall_req), 32'd0);
    chk("t5_handler_exl", 32'(exl), 32'd1);

    // Nested Sys in HANDLER with a coincident ERET
    exc_req = 6'b000100; eret = 1'b1; exc_pc = 32'h0040_2000;
    step();
    exc_req = '0; eret = 1'b0;
    chk("t4_exl_kept", 32'(exl), 32'd1);
    step();
    chk("t4_code_sys", 32'(exccode), 32'd8);
    chk("t4_no_epc_we", 32'(epc_we), 32'd0);
    step(); step();
    eret = 1'b1;
    step();
    eret = 1'b0;

    // Async reset while draining
    exc_req = 6'b100000; pipe_drained = 1'b0;
    step();
    exc_req = '0;
    step();
    async_reset_pulse();
    step();
    chk("t6_idle_after", 32'(stall_req), 32'd0);
    chk("t6_exl_after", 32'(exl), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      exc_req        = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
      if ($urandom_range(0, 7) == 0) irq = 5'($urandom);
      timer_pending  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) sw_int = 2'($urandom);
      status_ie      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) status_im = 8'($urandom);
      exc_pc         = $urandom;
      pipe_drained   = ($urandom_range(0, 2) == 0);
      redirect_ready = ($urandom_range(0, 1) == 0);
      eret           = ($urandom_range(0, 2) == 0);
      step();
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
